fifo_unpacker: RTL and testbench

FIFO_UNPACKER -- requirements
Module: fifo_unpacker

---
 rtl/dmix_pkg.sv | 14 +
 rtl/fifo_unpacker.sv | 104 ++++++++++
 tb/tb_fifo_unpacker.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dmix_pkg.sv
// rtl/dmix_pkg.sv - shared dmix constants: sample geometry and unpacker state encoding
package dmix_pkg;

    localparam int BYTES_PER_SAMPLE = 3;
    localparam int SAMPLE_W         = 8 * BYTES_PER_SAMPLE;

    typedef enum logic [1:0] {
        ST_B0   = 2'd0,
        ST_B1   = 2'd1,
        ST_B2   = 2'd2,
        ST_HOLD = 2'd3
    } unpack_state_e;

endpackage

// File: rtl/fifo_unpacker.sv
// rtl/fifo_unpacker.sv - assembles 24-bit samples from a byte-wide FWFT FIFO
// FIFO_UNPACKER_BIG_ENDIAN_EN places byte 0 in the top lane instead of the bottom.
module fifo_unpacker
    import dmix_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                fifo_empty_i,
    input  logic [7:0]          fifo_data_i,
    output logic                fifo_pop_o,
    input  logic                sync_i,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic                valid_o,
    input  logic                ack_i,
    output logic [15:0]         count_o
);

    unpack_state_e       state_q, state_d;
    logic [7:0]          b0_q, b0_d;
    logic [7:0]          b1_q, b1_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                valid_q, valid_d;
    logic [15:0]         count_q, count_d;
    logic                pop;
    logic                accept;

    function automatic logic [SAMPLE_W-1:0] assemble(input logic [7:0] b0,
                                                     input logic [7:0] b1,
                                                     input logic [7:0] b2);
`ifdef FIFO_UNPACKER_BIG_ENDIAN_EN
        return {b0, b1, b2};
`else
        return {b2, b1, b0};
`endif
    endfunction

    // A held sample only lets the next byte in when it is being accepted in the same edge.
    assign pop    = !rst && !sync_i && !fifo_empty_i && (state_q != ST_HOLD || ack_i);
    assign accept = valid_q && ack_i;

    always_comb begin
        state_d  = state_q;
        b0_d     = b0_q;
        b1_d     = b1_q;
        sample_d = sample_q;
        valid_d  = valid_q;
        count_d  = count_q;
        if (pop) begin
            case (state_q)
                ST_B0: begin
                    b0_d    = fifo_data_i;
                    state_d = ST_B1;
                end
                ST_B1: begin
                    b1_d    = fifo_data_i;
                    state_d = ST_B2;
                end
                ST_B2: begin
                    sample_d = assemble(b0_q, b1_q, fifo_data_i);
                    valid_d  = 1'b1;
                    state_d  = ST_HOLD;
                end
                default: begin
                    b0_d    = fifo_data_i;
                    valid_d = 1'b0;
                    count_d = count_q + 16'd1;
                    state_d = ST_B1;
                end
            endcase
        end else if (state_q == ST_HOLD && accept) begin
            valid_d = 1'b0;
            count_d = count_q + 16'd1;
            state_d = ST_B0;
        end else if (sync_i && (state_q == ST_B1 || state_q == ST_B2)) begin
            b0_d    = 8'd0;
            b1_d    = 8'd0;
            state_d = ST_B0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_B0;
            b0_q     <= 8'd0;
            b1_q     <= 8'd0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            count_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            b0_q     <= b0_d;
            b1_q     <= b1_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
        end
    end

    assign fifo_pop_o = pop;
    assign sample_o   = sample_q;
    assign valid_o    = valid_q;
    assign count_o    = count_q;

endmodule

// File: tb/tb_fifo_unpacker.sv
// tb/tb_fifo_unpacker.sv - directed self-checking bench for fifo_unpacker
module tb_fifo_unpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty_i;
    logic [7:0]  fifo_data_i;
    logic        fifo_pop_o;
    logic        sync_i;
    logic [23:0] sample_o;
    logic        valid_o;
    logic        ack_i;
    logic [15:0] count_o;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  q[$];
    logic        pop_seen;
    logic        flag;
    logic [23:0] held;

    fifo_unpacker dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_pop_o   (fifo_pop_o),
        .sync_i       (sync_i),
        .sample_o     (sample_o),
        .valid_o      (valid_o),
        .ack_i        (ack_i),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] exp_sample(input logic [7:0] b0, input logic [7:0] b1,
                                               input logic [7:0] b2);
`ifdef FIFO_UNPACKER_BIG_ENDIAN_EN
        return {b0, b1, b2};
`else
        return {b2, b1, b0};
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic upd();
        fifo_empty_i = (q.size() == 0);
        fifo_data_i  = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        upd();
    endtask

    // Called at a falling edge; returns at the next falling edge with the FIFO model updated.
    task automatic tick();
        #1;
        pop_seen = fifo_pop_o;
        @(posedge clk);
        if (pop_seen && q.size() != 0) void'(q.pop_front());
        @(negedge clk);
        upd();
    endtask

    initial begin
        rst    = 1'b1;
        sync_i = 1'b0;
        ack_i  = 1'b0;
        upd();
        @(negedge clk);
        push(8'hAA);
        tick();
        tick();
        chk("reset_pop", {31'd0, pop_seen}, 32'd0);
        chk("reset_valid", {31'd0, valid_o}, 32'd0);
        chk("reset_sample", {8'd0, sample_o}, 32'd0);
        chk("reset_count", {16'd0, count_o}, 32'd0);
        chk("reset_fifo_kept", q.size(), 32'd1);
        q.delete();
        upd();

        // basic sample with ack held high
        rst   = 1'b0;
        ack_i = 1'b1;
        push(8'h21); push(8'h22); push(8'h23);
        tick(); tick();
        chk("basic_not_yet_valid", {31'd0, valid_o}, 32'd0);
        tick();
        chk("basic_valid", {31'd0, valid_o}, 32'd1);
        chk("basic_sample", {8'd0, sample_o}, {8'd0, exp_sample(8'h21, 8'h22, 8'h23)});
        tick();
        chk("basic_valid_one_cycle", {31'd0, valid_o}, 32'd0);
        chk("basic_count", {16'd0, count_o}, 32'd1);

        // six preloaded bytes: back-to-back pops, samples three cycles apart
        for (int i = 1; i <= 6; i++) push(i[7:0]);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("stream_pop%0d", i), {31'd0, pop_seen}, (i < 6) ? 32'd1 : 32'd0);
            chk($sformatf("stream_valid%0d", i), {31'd0, valid_o},
                (i == 2 || i == 5) ? 32'd1 : 32'd0);
            if (i == 2) chk("stream_s0", {8'd0, sample_o}, {8'd0, exp_sample(8'h01, 8'h02, 8'h03)});
            if (i == 5) chk("stream_s1", {8'd0, sample_o}, {8'd0, exp_sample(8'h04, 8'h05, 8'h06)});
        end
        chk("stream_count", {16'd0, count_o}, 32'd3);

        // FIFO runs dry mid-sample: stall without timeout
        push(8'h21); push(8'h22);
        tick(); tick();
        flag = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid_o !== 1'b0) flag = 1'b1;
        end
        chk("stall_no_valid", {31'd0, flag}, 32'd0);
        chk("stall_ack_ignored", {16'd0, count_o}, 32'd3);
        push(8'h23);
        tick();
        chk("stall_valid", {31'd0, valid_o}, 32'd1);
        chk("stall_sample", {8'd0, sample_o}, {8'd0, exp_sample(8'h21, 8'h22, 8'h23)});
        tick();
        chk("stall_count", {16'd0, count_o}, 32'd4);

        // sync discards a partial sample
        push(8'h21);
        tick();
        sync_i = 1'b1;
        push(8'h30);
        tick();
        chk("sync_no_pop", {31'd0, pop_seen}, 32'd0);
        sync_i = 1'b0;
        push(8'h31); push(8'h32);
        tick(); tick(); tick();
        chk("sync_valid", {31'd0, valid_o}, 32'd1);
        chk("sync_sample", {8'd0, sample_o}, {8'd0, exp_sample(8'h30, 8'h31, 8'h32)});
        tick();
        chk("sync_count", {16'd0, count_o}, 32'd5);

        // backpressure: ack low holds the sample and blocks the FIFO
        ack_i = 1'b0;
        push(8'h41); push(8'h42); push(8'h43); push(8'h44);
        tick(); tick(); tick();
        held = sample_o;
        chk("bp_sample", {8'd0, held}, {8'd0, exp_sample(8'h41, 8'h42, 8'h43)});
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pop_seen !== 1'b0 || valid_o !== 1'b1 || sample_o !== held) flag = 1'b1;
        end
        chk("bp_held", {31'd0, flag}, 32'd0);
        ack_i = 1'b1;
        tick();
        chk("bp_pop_with_ack", {31'd0, pop_seen}, 32'd1);
        chk("bp_valid_fall", {31'd0, valid_o}, 32'd0);
        chk("bp_count", {16'd0, count_o}, 32'd6);
        push(8'h45); push(8'h46);
        tick(); tick();
        chk("bp_next_sample", {8'd0, sample_o}, {8'd0, exp_sample(8'h44, 8'h45, 8'h46)});
        tick();
        chk("bp_next_count", {16'd0, count_o}, 32'd7);

        // sync while holding leaves the sample valid
        ack_i = 1'b0;
        push(8'h51); push(8'h52); push(8'h53);
        tick(); tick(); tick();
        sync_i = 1'b1;
        tick();
        sync_i = 1'b0;
        chk("hold_sync_valid", {31'd0, valid_o}, 32'd1);
        chk("hold_sync_sample", {8'd0, sample_o}, {8'd0, exp_sample(8'h51, 8'h52, 8'h53)});
        ack_i = 1'b1;
        tick();
        chk("hold_sync_count", {16'd0, count_o}, 32'd8);

        // reset in B2 discards the partial sample without popping
        push(8'h61); push(8'h62);
        tick(); tick();
        rst = 1'b1;
        push(8'h63);
        tick();
        chk("rst_b2_no_pop", {31'd0, pop_seen}, 32'd0);
        chk("rst_b2_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_b2_count", {16'd0, count_o}, 32'd0);
        rst = 1'b0;
        push(8'h64); push(8'h65);
        tick(); tick(); tick();
        chk("rst_fresh_sample", {8'd0, sample_o}, {8'd0, exp_sample(8'h63, 8'h64, 8'h65)});
        tick();
        chk("rst_fresh_count", {16'd0, count_o}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
